// File: rtl/paddle_ctrl_if.sv
// -----------------------------------------------------------------------------
// paddle_ctrl_if
// Groups the paddle controller's button/sync inputs and position outputs.
//   btn_up, btn_down : raw asynchronous buttons, active-high
//   vsync            : vertical sync from the timing generator, active-high
//   paddle_vpos      : registered paddle top line, 0..MAX_POS
//   at_limit         : registered, high when paddle_vpos is 0 or MAX_POS
//   motion_state     : debug view of the motion FSM (0 IDLE, 1 UP, 2 DOWN)
// Modports: master = the side driving the buttons/vsync (board or bench),
//           slave  = paddle_ctrl.
// All signals are level-based; there is no valid/ready handshake on this
// interface. Buttons and vsync may change at any time and are synchronized
// inside the controller.
// -----------------------------------------------------------------------------
interface paddle_ctrl_if;
   logic       btn_up;
   logic       btn_down;
   logic       vsync;
   logic [9:0] paddle_vpos;
   logic       at_limit;
   logic [1:0] motion_state;

   modport master (
      output btn_up, btn_down, vsync,
      input  paddle_vpos, at_limit, motion_state
   );

   modport slave (
      input  btn_up, btn_down, vsync,
      output paddle_vpos, at_limit, motion_state
   );
endinterface

// File: rtl/paddle_ctrl.sv
// -----------------------------------------------------------------------------
// paddle_ctrl
// Turns two raw buttons into a paddle position that moves once per frame.
// Buttons and vsync are synchronized, buttons debounced, and the motion FSM
// (IDLE/UP/DOWN) is evaluated only on the vsync rising edge (frame_tick).
// Ports:
//   clk   : pixel clock, all state on rising edge
//   reset : synchronous, active-high
//   pif   : paddle_ctrl_if.slave (btn_up, btn_down, vsync in;
//           paddle_vpos, at_limit, motion_state out)
// Configuration macro: PADDLE_ACCEL_EN
//   defined   -> step grows with the number of consecutive frames held in
//                the same direction (SPEED, 2*SPEED, 4*SPEED)
//   undefined -> step is always SPEED
// -----------------------------------------------------------------------------
module paddle_ctrl #(
   parameter int DEB_BITS = 16,
   parameter int SPEED    = 4,
   parameter int MAX_POS  = 430,
   parameter int INIT_POS = 215
) (
   input  logic          clk,
   input  logic          reset,
   paddle_ctrl_if.slave  pif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } motion_t;

   localparam logic [DEB_BITS-1:0] DEB_MAX = '1;
   localparam logic [9:0] MAX_POS_V  = 10'(MAX_POS);
   localparam logic [9:0] INIT_POS_V = 10'(INIT_POS);

   // bit 0 = up, bit 1 = down
   logic [1:0]          btn_s1, btn_s2;
   logic                vs_s1, vs_s2, vs_prev;
   logic                frame_tick;
   logic [DEB_BITS-1:0] deb_cnt [2];
   logic [1:0]          stable;

   motion_t    state, state_next;
   logic [9:0] vpos, vpos_next;
   logic       at_limit_q;
   logic [9:0] step;
   logic [10:0] sum;

   // Two-flop synchronizers plus the previous vsync sample for edge detect.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1  <= '0;
         btn_s2  <= '0;
         vs_s1   <= 1'b0;
         vs_s2   <= 1'b0;
         vs_prev <= 1'b0;
      end else begin
         btn_s1  <= {pif.btn_down, pif.btn_up};
         btn_s2  <= btn_s1;
         vs_s1   <= pif.vsync;
         vs_s2   <= vs_s1;
         vs_prev <= vs_s2;
      end
   end

   assign frame_tick = vs_s2 & ~vs_prev;

   // Debouncers: a differing level must persist for 2^DEB_BITS clocks; any
   // return to the stable level restarts the count.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            deb_cnt[i] <= '0;
            stable[i]  <= 1'b0;
         end else if (btn_s2[i] == stable[i]) begin
            deb_cnt[i] <= '0;
         end else if (deb_cnt[i] == DEB_MAX) begin
            stable[i]  <= btn_s2[i];
            deb_cnt[i] <= '0;
         end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
         end
      end
   end

   // Motion FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Motion FSM: next state, sampled only at frame_tick
   always_comb begin
      state_next = state;
      if (frame_tick) begin
         case (stable)
            2'b01:   state_next = UP;
            2'b10:   state_next = DOWN;
            default: state_next = IDLE;
         endcase
      end
   end

`ifdef PADDLE_ACCEL_EN
   logic [4:0] hold_cnt, hold_eff;

   // A frame that changes direction (or leaves IDLE) starts from count 0.
   always_comb begin
      hold_eff = (state_next == state) ? hold_cnt : 5'd0;
      if (hold_eff < 5'd8)       step = 10'(SPEED);
      else if (hold_eff < 5'd16) step = 10'(2 * SPEED);
      else                       step = 10'(4 * SPEED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt <= '0;
      end else if (frame_tick) begin
         if (state_next == IDLE)    hold_cnt <= '0;
         else if (hold_eff != '1)   hold_cnt <= hold_eff + 5'd1;
         else                       hold_cnt <= hold_eff;
      end
   end
`else
   assign step = 10'(SPEED);
`endif

   // Position update computed in the frame_tick cycle, registered on the
   // following edge. Subtraction is clamped before it can wrap; addition is
   // done one bit wider so the MAX_POS compare sees the true sum.
   always_comb begin
      vpos_next = vpos;
      sum       = {1'b0, vpos} + {1'b0, step};
      if (frame_tick) begin
         if (state_next == UP) begin
            vpos_next = (vpos < step) ? 10'd0 : vpos - step;
         end else if (state_next == DOWN) begin
            vpos_next = (sum > {1'b0, MAX_POS_V}) ? MAX_POS_V : sum[9:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vpos       <= INIT_POS_V;
         at_limit_q <= 1'b0;
      end else begin
         vpos       <= vpos_next;
         at_limit_q <= (vpos_next == 10'd0) || (vpos_next == MAX_POS_V);
      end
   end

   assign pif.paddle_vpos  = vpos;
   assign pif.at_limit     = at_limit_q;
   assign pif.motion_state = state;

endmodule

// File: tb/tb_paddle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_paddle_ctrl
// Directed bench for paddle_ctrl with DEB_BITS=4, SPEED=4, MAX_POS=430,
// INIT_POS=215. Inputs change and outputs are sampled on the falling edge.
// Build with +define+PADDLE_ACCEL_EN to exercise the acceleration sequence
// instead of the fixed-step clamp sweeps.
// -----------------------------------------------------------------------------
module tb_paddle_ctrl;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  paddle_ctrl_if pif();

  paddle_ctrl #(
    .DEB_BITS (4),
    .SPEED    (4),
    .MAX_POS  (430),
    .INIT_POS (215)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reset from a falling edge; position must be INIT_POS one edge later.
  task automatic apply_reset(input string tag);
    reset    = 1'b1;
    pif.vsync = 1'b0;
    @(negedge clk);
    check_val({tag, "_pos"}, pif.paddle_vpos, 10'd215);
    check_val({tag, "_lim"}, {9'd0, pif.at_limit}, 10'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Set buttons and wait well past sync (2) + debounce (16) latency.
  task automatic set_btns(input logic up, input logic down);
    pif.btn_up   = up;
    pif.btn_down = down;
    repeat (25) @(negedge clk);
  endtask

  // One vsync pulse. frame_tick is the 3rd cycle after raising vsync, so
  // the position must be unchanged at the 2nd falling edge and updated at
  // the 3rd.
  task automatic do_frame(input string tag, input logic [9:0] pre,
                          input logic [9:0] post, input logic lim);
    pif.vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val({tag, "_pre"}, pif.paddle_vpos, pre);
    @(negedge clk);
    check_val({tag, "_post"}, pif.paddle_vpos, post);
    check_val({tag, "_lim"}, {9'd0, pif.at_limit}, {9'd0, lim});
    repeat (3) @(negedge clk);
    pif.vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [9:0] accel_step(input int k);
    if (k < 8)       return 10'd4;
    else if (k < 16) return 10'd8;
    else             return 10'd16;
  endfunction

  initial begin
    logic [9:0] pos;
    logic [9:0] nxt;
    logic [9:0] stp;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    pif.btn_up   = 1'b0;
    pif.btn_down = 1'b0;
    pif.vsync    = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_pos", pif.paddle_vpos, 10'd215);
    check_val("reset_lim", {9'd0, pif.at_limit}, 10'd0);
    check_val("reset_state", {8'd0, pif.motion_state}, 10'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // no buttons: position holds
    for (int i = 0; i < 3; i++) do_frame($sformatf("idle%0d", i), 10'd215, 10'd215, 1'b0);

    // btn_down held: +4 per frame
    set_btns(1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      do_frame($sformatf("down%0d", i), 10'(215 + 4 * i), 10'(219 + 4 * i), 1'b0);
    set_btns(1'b0, 1'b0);
    do_frame("release", 10'd235, 10'd235, 1'b0);

    // reset in the middle of motion discards position
    apply_reset("rst_motion");

    // glitches shorter than 16 clocks are rejected
    pif.btn_up = 1'b1;
    repeat (10) @(negedge clk);
    pif.btn_up = 1'b0;
    repeat (25) @(negedge clk);
    do_frame("glitch10", 10'd215, 10'd215, 1'b0);
    pif.btn_up = 1'b1;
    repeat (15) @(negedge clk);
    pif.btn_up = 1'b0;
    repeat (25) @(negedge clk);
    do_frame("glitch15", 10'd215, 10'd215, 1'b0);

    // both buttons: IDLE, no motion
    set_btns(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) do_frame($sformatf("both%0d", i), 10'd215, 10'd215, 1'b0);
    check_val("both_state", {8'd0, pif.motion_state}, 10'd0);

    // a debounced press without vsync causes no mid-frame motion
    set_btns(1'b0, 1'b1);
    check_val("midframe_pos", pif.paddle_vpos, 10'd215);
    check_val("midframe_state", {8'd0, pif.motion_state}, 10'd0);

`ifdef PADDLE_ACCEL_EN
    apply_reset("rst_accel");
    set_btns(1'b1, 1'b0);
    pos = 10'd215;
    for (int k = 0; k < 40 && pos != 10'd0; k++) begin
      stp = accel_step(k);
      nxt = (pos > stp) ? pos - stp : 10'd0;
      do_frame($sformatf("aup%0d", k), pos, nxt, (nxt == 10'd0));
      pos = nxt;
    end
    check_val("accel_top", pif.paddle_vpos, 10'd0);
    set_btns(1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      stp = accel_step(k);
      nxt = pos + stp;
      do_frame($sformatf("adn%0d", k), pos, nxt, 1'b0);
      pos = nxt;
    end
    check_val("accel_final", pif.paddle_vpos, 10'd160);
    do_frame("adn20", 10'd160, 10'd176, 1'b0);
    // reset mid-sequence, during a vsync pulse
    pif.vsync = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("accel_rst_pos", pif.paddle_vpos, 10'd215);
    check_val("accel_rst_state", {8'd0, pif.motion_state}, 10'd0);
    pif.vsync = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`else
    // upper clamp: 215 -> 3 in 53 frames, then clamp at 0
    apply_reset("rst_sweep");
    set_btns(1'b1, 1'b0);
    for (int k = 0; k < 53; k++)
      do_frame($sformatf("up%0d", k), 10'(215 - 4 * k), 10'(211 - 4 * k), 1'b0);
    do_frame("up_clamp", 10'd3, 10'd0, 1'b1);
    do_frame("up_stay", 10'd0, 10'd0, 1'b1);
    // lower clamp: 0 -> 428 in 107 frames, then clamp at 430
    set_btns(1'b0, 1'b1);
    for (int k = 0; k < 107; k++)
      do_frame($sformatf("dn%0d", k), 10'(4 * k), 10'(4 * k + 4), 1'b0);
    do_frame("dn_clamp", 10'd428, 10'd430, 1'b1);
    do_frame("dn_stay", 10'd430, 10'd430, 1'b1);
    check_val("dn_state", {8'd0, pif.motion_state}, 10'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
